// File: rtl/serial_alu_seq_if.sv
// Operand/result bus between the CPU control unit and the bit-serial ALU.
interface serial_alu_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start_i;
    logic             op_sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             overflow_o;
    logic             zero_o;
    logic             busy_o;
    logic             done_o;

    // Control unit side: issues operations, consumes results.
    modport master (
        output start_i, op_sub_i, a_i, b_i,
        input  result_o, carry_o, overflow_o, zero_o, busy_o, done_o
    );

    // ALU side.
    modport slave (
        input  start_i, op_sub_i, a_i, b_i,
        output result_o, carry_o, overflow_o, zero_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, carry held in a flop.
// Subtraction is A + ~B + 1, with the +1 preloaded as the initial carry.

// Single-bit full adder cell shared by every bit position.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_alu_seq_if.slave      bus_io
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             cy_q, cy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    full_adder u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (cy_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    // Partial result after this bit: new sum bit enters at the MSB.
    assign res_next = {fa_sum, res_sr_q[WIDTH-1:1]};

    // Next-state: operand load on accepted start, one bit per cycle in RUN.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus_io.start_i) begin
                    a_sr_d  = bus_io.a_i;
                    b_sr_d  = bus_io.op_sub_i ? ~bus_io.b_i : bus_io.b_i;
                    cy_d    = bus_io.op_sub_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_next;
                cy_d     = fa_cout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Signed overflow: carry into MSB differs from carry out of it.
                    ovf_d    = cy_q ^ fa_cout;
                    carry_d  = fa_cout;
                    result_d = res_next;
                    zero_d   = (res_next == '0);
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus_io.result_o   = result_q;
    assign bus_io.carry_o    = carry_q;
    assign bus_io.overflow_o = ovf_q;
    assign bus_io.zero_o     = zero_q;
    assign bus_io.busy_o     = (state_q == StRun);
    assign bus_io.done_o     = (state_q == StDone);
endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: transaction-level model checked every cycle (WIDTH=4),
// directed literal vectors, exhaustive 4-bit sweep and sampled 8-bit operations.
module tb_serial_alu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_alu_seq_if #(.WIDTH(4)) bus4 ();
    serial_alu_seq_if #(.WIDTH(8)) bus8 ();

    serial_alu_seq #(.WIDTH(4)) dut4 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus4)
    );

    serial_alu_seq #(.WIDTH(8)) dut8 (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {zero, overflow, carry, result[15:0]}.
    function automatic logic [18:0] ref_op(input int w, input int a, input int b, input bit sub);
        int  mask;
        int  r;
        bit  c;
        bit  v;
        bit  sa;
        bit  sb;
        bit  sr;
        mask = (1 << w) - 1;
        if (sub) begin
            r = (a - b) & mask;
            c = (a >= b);
        end else begin
            r = (a + b) & mask;
            c = ((a + b) > mask);
        end
        sa = ((a >> (w - 1)) & 1) != 0;
        sb = ((b >> (w - 1)) & 1) != 0;
        sr = ((r >> (w - 1)) & 1) != 0;
        v  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {(r == 0), v, c, 16'(r)};
    endfunction

    // Transaction model for the WIDTH=4 instance, advanced on every rising edge.
    int          edge_n = 0;
    bit          m_on = 1'b0;
    bit          m_pend = 1'b0;
    int          m_acc = 0;
    int          m_done_edge = -10;
    logic [18:0] m_txn = '0;
    logic [18:0] m_out = '0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_on        = 1'b1;
            m_pend      = 1'b0;
            m_done_edge = -10;
            m_out       = '0;
        end else if (m_on) begin
            if (m_pend && edge_n == m_acc + 4) begin
                m_out       = m_txn;
                m_pend      = 1'b0;
                m_done_edge = edge_n;
            end else if (!m_pend && bus4.start_i) begin
                m_pend = 1'b1;
                m_acc  = edge_n;
                m_txn  = ref_op(4, int'(bus4.a_i), int'(bus4.b_i), bus4.op_sub_i);
            end
        end
    end

    // Per-cycle comparison of the WIDTH=4 instance against the model.
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy", 32'(bus4.busy_o), 32'(m_pend));
            chk("done", 32'(bus4.done_o), 32'(m_done_edge == edge_n));
            chk("result", 32'(bus4.result_o), 32'(m_out[3:0]));
            chk("carry", 32'(bus4.carry_o), 32'(m_out[16]));
            chk("overflow", 32'(bus4.overflow_o), 32'(m_out[17]));
            chk("zero", 32'(bus4.zero_o), 32'(m_out[18]));
        end
    end

    // One WIDTH=4 operation; returns flags/result at done, latency and busy cycle count.
    task automatic op4(input int a, input int b, input bit sub,
                       output logic [18:0] got, output int lat, output int busy_n);
        got    = 'x;
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        bus4.a_i      = a[3:0];
        bus4.b_i      = b[3:0];
        bus4.op_sub_i = sub;
        bus4.start_i  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus4.start_i = 1'b0;
            busy_n += int'(bus4.busy_o);
            if (bus4.done_o) begin
                lat = k;
                got = {bus4.zero_o, bus4.overflow_o, bus4.carry_o, 16'(bus4.result_o)};
                break;
            end
        end
    endtask

    task automatic op8(input int a, input int b, input bit sub,
                       output logic [18:0] got, output int lat);
        got = 'x;
        lat = 0;
        @(negedge clk);
        bus8.a_i      = a[7:0];
        bus8.b_i      = b[7:0];
        bus8.op_sub_i = sub;
        bus8.start_i  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) bus8.start_i = 1'b0;
            if (bus8.done_o) begin
                lat = k;
                got = {bus8.zero_o, bus8.overflow_o, bus8.carry_o, 16'(bus8.result_o)};
                break;
            end
        end
    endtask

    // Directed vectors: a, b, sub, result, carry, overflow, zero.
    int dv [6][7] = '{
        '{7, 5, 0, 12, 0, 1, 0},
        '{9, 7, 0,  0, 1, 0, 1},
        '{0, 0, 0,  0, 0, 0, 1},
        '{5, 3, 1,  2, 1, 0, 0},
        '{3, 5, 1, 14, 0, 0, 0},
        '{8, 1, 1,  7, 1, 1, 0}
    };

    // Operand sets for the held-start stream: a, b, sub.
    int hv [4][3] = '{
        '{3, 4, 0}, '{15, 1, 0}, '{2, 7, 1}, '{6, 6, 1}
    };

    initial begin
        logic [18:0] got;
        logic [18:0] exp;
        int          lat;
        int          busy_n;
        int          dones;
        int          last_done;
        int          cyc;

        rst = 1'b1;
        bus4.start_i = 1'b0; bus4.op_sub_i = 1'b0; bus4.a_i = '0; bus4.b_i = '0;
        bus8.start_i = 1'b0; bus8.op_sub_i = 1'b0; bus8.a_i = '0; bus8.b_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus4.busy_o), 0);
        chk("rst_done", 32'(bus4.done_o), 0);
        chk("rst_result", 32'(bus4.result_o), 0);
        chk("rst_zero", 32'(bus4.zero_o), 0);
        rst = 1'b0;

        // Directed vectors: literal results, model sanity, latency and busy length.
        for (int i = 0; i < 6; i++) begin
            exp = {dv[i][6][0], dv[i][5][0], dv[i][4][0], 16'(dv[i][3])};
            chk("model_literal", 32'(ref_op(4, dv[i][0], dv[i][1], dv[i][2][0])), 32'(exp));
            op4(dv[i][0], dv[i][1], dv[i][2][0], got, lat, busy_n);
            chk("dir_result", 32'(got), 32'(exp));
            chk("dir_latency", lat, 5);
            chk("dir_busy_cycles", busy_n, 4);
        end

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        bus4.a_i = 4'd7; bus4.b_i = 4'd5; bus4.op_sub_i = 1'b0; bus4.start_i = 1'b1;
        @(negedge clk);
        bus4.start_i = 1'b0;
        @(negedge clk);
        bus4.a_i = 4'd1; bus4.b_i = 4'd1; bus4.start_i = 1'b1;
        @(negedge clk);
        bus4.start_i = 1'b0;
        dones = 0;
        got   = 'x;
        for (int k = 0; k < 10; k++) begin
            if (bus4.done_o) begin
                dones++;
                got = 19'(bus4.result_o);
            end
            @(negedge clk);
        end
        chk("ign_dones", dones, 1);
        chk("ign_result", 32'(got), 32'hC);

        // Reset in the second RUN cycle aborts without a done pulse.
        bus4.a_i = 4'd7; bus4.b_i = 4'd5; bus4.start_i = 1'b1;
        @(negedge clk);
        bus4.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus4.busy_o), 0);
        chk("abort_done", 32'(bus4.done_o), 0);
        chk("abort_result", 32'(bus4.result_o), 0);
        chk("abort_carry", 32'(bus4.carry_o), 0);
        chk("abort_ovf", 32'(bus4.overflow_o), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            dones += int'(bus4.done_o);
        end
        chk("abort_no_done", dones, 0);

        // start_i held high: new operands presented on each done.
        bus4.a_i = hv[0][0][3:0]; bus4.b_i = hv[0][1][3:0]; bus4.op_sub_i = hv[0][2][0];
        bus4.start_i = 1'b1;
        cyc       = 0;
        last_done = -1;
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                cyc++;
                if (bus4.done_o) begin
                    lat = 1;
                    break;
                end
            end
            chk("held_done_seen", lat, 1);
            exp = ref_op(4, hv[i][0], hv[i][1], hv[i][2][0]);
            chk("held_result", 32'(bus4.result_o), 32'(exp[3:0]));
            if (i > 0) chk("held_interval", cyc - last_done, 5);
            last_done = cyc;
            if (i < 3) begin
                bus4.a_i = hv[i+1][0][3:0]; bus4.b_i = hv[i+1][1][3:0];
                bus4.op_sub_i = hv[i+1][2][0];
            end else begin
                bus4.start_i = 1'b0;
            end
        end
        repeat (2) @(negedge clk);

        // Exhaustive 4-bit sweep, both operations.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    op4(a, b, s[0], got, lat, busy_n);
                    chk("sweep", 32'(got), 32'(ref_op(4, a, b, s[0])));
                    if (lat != 5) chk("sweep_latency", lat, 5);
                end
            end
        end

        // 8-bit instance: boundary vectors then sampled operands.
        chk("model_w8_literal", 32'(ref_op(8, 127, 1, 1'b0)), 32'({3'b010, 16'h0080}));
        op8(127, 1, 1'b0, got, lat);
        chk("w8_127p1", 32'(got), 32'({3'b010, 16'h0080}));
        chk("w8_latency", lat, 9);
        op8(255, 1, 1'b0, got, lat);
        chk("w8_255p1", 32'(got), 32'({3'b101, 16'h0000}));
        op8(128, 1, 1'b1, got, lat);
        chk("w8_128m1", 32'(got), 32'({3'b011, 16'h007F}));
        for (int i = 0; i < 40; i++) begin
            int ra;
            int rb;
            bit rs;
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            op8(ra, rb, rs, got, lat);
            chk("w8_sample", 32'(got), 32'(ref_op(8, ra, rb, rs)));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
